// File: rtl/fifo.sv
// fifo: single-clock FIFO of 3-bit {rs2, rs1, rs} samples with registered flags and error pulses
module fifo #(
  parameter int DEPTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rs,
  input  logic                  rs1,
  input  logic                  rs2,
  input  logic                  enable,
  input  logic                  rd,
  output logic [2:0]            dout,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  wr_err,
  output logic                  rd_err
);
  logic [2:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic                  push, pop;
  logic [ADDR_WIDTH:0]   count_nx;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside a read
  always_comb begin
    pop = rd && !empty;
    push = enable && (!full || pop);
    count_nx = push && !pop ? count + 1'b1 : pop && !push ? count - 1'b1 : count;
  end
  // Storage is deliberately left out of reset; only pointers define validity
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {rs2, rs1, rs};
  // Pointers, occupancy, registered flags, read data and one-cycle error pulses
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      dout <= '0;
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr];
      end
      count <= count_nx;
      empty <= count_nx == '0;
      full <= count_nx == (ADDR_WIDTH+1)'(DEPTH);
      wr_err <= enable && full && !rd;
      rd_err <= rd && empty;
    end
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: scoreboard bench for fifo with a reference queue model
module tb_fifo;
  localparam int DEPTH = 16;
  logic clk = 0, reset = 0, rs = 0, rs1 = 0, rs2 = 0, enable = 0, rd = 0;
  logic [2:0] dout;
  logic [4:0] count;
  logic empty, full, wr_err, rd_err;
  int n_chk = 0, n_fail = 0;
  logic [2:0] sb[$];
  logic [2:0] exp_dout = 0;
  logic exp_werr = 0, exp_rerr = 0;

  fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rs1(rs1), .rs2(rs2), .enable(enable), .rd(rd),
    .dout(dout), .count(count), .empty(empty), .full(full), .wr_err(wr_err), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    check("count", count, sb.size());
    check("empty", empty, sb.size() == 0);
    check("full", full, sb.size() == DEPTH);
    check("dout", dout, exp_dout);
    check("wr_err", wr_err, exp_werr);
    check("rd_err", rd_err, exp_rerr);
  endtask

  task automatic cycle(input logic en, input logic r, input logic [2:0] d);
    logic mpop, mpush;
    enable = en;
    rd = r;
    {rs2, rs1, rs} = d;
    mpop = r && sb.size() > 0;
    mpush = en && (sb.size() < DEPTH || mpop);
    exp_werr = en && sb.size() == DEPTH && !r;
    exp_rerr = r && sb.size() == 0;
    if (mpop) exp_dout = sb.pop_front();
    if (mpush) sb.push_back(d);
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    reset = 1;
    #1;
    check_state();
    for (int i = 0; i < 17; i++) cycle(1, 0, 3'd7);
    cycle(0, 0, 0);
    while (sb.size() > 0) cycle(0, 1, 0);
    cycle(0, 1, 0);
    for (int i = 1; i <= 8; i++) cycle(1, 0, 3'(i));
    for (int i = 0; i < 9; i++) cycle(0, 1, 0);
    cycle(0, 0, 0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, 3'($urandom_range(0, 7)));
      for (int i = 0; i < 36; i++) cycle(0, (i / 3) % 2 == 0, 0);
    end
    while (sb.size() < DEPTH) cycle(1, 0, 3'($urandom_range(0, 7)));
    for (int i = 0; i < 5; i++) cycle(1, 1, 3'($urandom_range(0, 7)));
    while (sb.size() > 0) cycle(0, 1, 0);
    cycle(1, 1, 3'd5);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    for (int i = 0; i < 9; i++) cycle(1, 0, 3'($urandom_range(1, 7)));
    enable = 0;
    rd = 0;
    #3;
    reset = 0;
    #2;
    sb.delete();
    exp_dout = 0;
    exp_werr = 0;
    exp_rerr = 0;
    check_state();
    #1;
    reset = 1;
    for (int i = 0; i < 6; i++) cycle(1, 0, 3'(i + 2));
    for (int i = 0; i < 7; i++) cycle(0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
